// File: rtl/sweep_ctrl_if.sv
// Interface bundle for sweep_ctrl. It carries the sweep request and the
// counter feedback in, and the counter control and status pulses out.
interface sweep_ctrl_if #(
   parameter int n  = 8,
   parameter int dw = 8
);
   logic          start;
   logic          stop;
   logic [n-1:0]  lo;
   logic [n-1:0]  hi;
   logic [dw-1:0] div;
   logic [7:0]    cycles;
   logic [n-1:0]  Q;
   logic          L;
   logic [n-1:0]  R;
   logic          E;
   logic          up_down;
   logic          busy;
   logic          turn;
   logic          done;
   logic          err;

   modport master (
      output start, stop, lo, hi, div, cycles, Q,
      input  L, R, E, up_down, busy, turn, done, err
   );

   modport slave (
      input  start, stop, lo, hi, div, cycles, Q,
      output L, R, E, up_down, busy, turn, done, err
   );
endinterface

// File: rtl/sweep_ctrl.sv
// Sweep controller. It drives an external up/down counter back and forth
// between lo and hi, and it advances the counter one step per prescaler tick.
//
// state | meaning
// IDLE  | waiting for start; latched parameters hold the last sweep
// LOAD  | one cycle: load the counter with lo and clear the prescaler
// UP    | step +1 on each tick until Q reaches hi, then reverse
// DOWN  | step -1 on each tick until Q reaches lo, then count a round trip
module sweep_ctrl #(
   parameter int n  = 8,
   parameter int dw = 8
) (
   input  logic        clk,
   input  logic        rst,
   sweep_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, UP, DOWN} state_t;

   state_t        state, state_nx;
   logic [n-1:0]  lo_l, hi_l;
   logic [dw-1:0] div_l, psc;
   logic [7:0]    cycles_l, round_cnt, round_nx;
   logic          err_q, tick, accept, reject, stepping;
   logic          e_c, turn_c, done_c;

   assign stepping = (state == UP) || (state == DOWN);
   assign tick     = stepping && (psc == div_l);
   assign accept   = (state == IDLE) && bus.start && !bus.stop && (bus.lo < bus.hi);
   assign reject   = (state == IDLE) && bus.start && !bus.stop && !(bus.lo < bus.hi);
   assign round_nx = round_cnt + 8'd1;

   always_comb begin
      state_nx = state;
      e_c      = 1'b0;
      turn_c   = 1'b0;
      done_c   = 1'b0;
      if (bus.stop) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) state_nx = LOAD;
            LOAD: state_nx = UP;
            UP: begin
               if (tick) begin
                  if (bus.Q < hi_l) begin
                     e_c = 1'b1;
                  end else begin
                     turn_c   = 1'b1;
                     state_nx = DOWN;
                  end
               end
            end
            DOWN: begin
               if (tick) begin
                  if (bus.Q > lo_l) begin
                     e_c = 1'b1;
                  end else begin
                     turn_c   = 1'b1;
                     state_nx = UP;
                     // A count of zero means sweep forever, so no done pulse.
                     if ((cycles_l != 8'd0) && (round_nx == cycles_l)) begin
                        done_c   = 1'b1;
                        state_nx = IDLE;
                     end
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         psc       <= '0;
         round_cnt <= '0;
         lo_l      <= '0;
         hi_l      <= '0;
         div_l     <= '0;
         cycles_l  <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= reject;
         if (stepping && !bus.stop) psc <= tick ? '0 : psc + 1'b1;
         else                       psc <= '0;
         if (accept) begin
            lo_l      <= bus.lo;
            hi_l      <= bus.hi;
            div_l     <= bus.div;
            cycles_l  <= bus.cycles;
            round_cnt <= '0;
         end else if (turn_c && (state == DOWN)) begin
            round_cnt <= round_nx;
         end
      end
   end

   assign bus.L       = (state == LOAD);
   assign bus.R       = lo_l;
   assign bus.E       = e_c;
   assign bus.up_down = (state != DOWN);
   assign bus.busy    = (state != IDLE);
   assign bus.turn    = turn_c;
   assign bus.done    = done_c;
   assign bus.err     = err_q;
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the count/data width.
REQ-002 The block SHALL have parameter dw, default 8, giving the prescaler width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begins a sweep when sampled high in IDLE.
REQ-006 stop  in  1  aborts any sweep; returns to IDLE.
REQ-007 lo  in  n  lower sweep bound (unsigned), sampled with start.
REQ-008 hi  in  n  upper sweep bound (unsigned), sampled with start.
REQ-009 div  in  dw  step period minus one, sampled with start.
REQ-010 cycles  in  8  round trips to perform, sampled with start; 0 = run until stop.
REQ-011 Q  in  n  current value fed back from the downstream up/down counter.
REQ-012 L  out  1  counter load strobe.
REQ-013 R  out  n  counter load value.
REQ-014 E  out  1  counter step enable.
REQ-015 up_down  out  1  counter direction: 1 = +1, 0 = -1.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 turn  out  1  one-cycle pulse on each direction reversal.
REQ-018 done  out  1  one-cycle pulse when the requested round trips complete.
REQ-019 err  out  1  one-cycle pulse when start is rejected for bad bounds.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, UP, DOWN.
REQ-021 IDLE: on start with lo < hi, latch lo/hi/div/cycles and go to LOAD; with lo >= hi, stay in IDLE and pulse err in the next cycle.
REQ-022 LOAD (one cycle): L=1, R=latched lo, E=0; next state UP; prescaler cleared.
REQ-023 Prescaler: dw-bit counter active in UP/DOWN; tick=1 when it equals latched div, then it wraps to 0; div=0 gives a tick every cycle.
REQ-024 UP: on tick with Q < hi_l, E=1 and up_down=1; on tick with Q >= hi_l, E=0, turn=1, next state DOWN.
REQ-025 DOWN: on tick with Q > lo_l, E=1 and up_down=0; on tick with Q <= lo_l, E=0, turn=1, round counter +1, next state UP.
REQ-026 If cycles_l != 0 and the round counter reaches cycles_l on the DOWN->UP reversal, done=1 in that same cycle and next state SHALL be IDLE, not UP.
REQ-027 E, up_down, turn and done SHALL be combinational from state, tick, Q and latched bounds; E=0 outside UP/DOWN.
REQ-028 up_down SHALL be 1 in IDLE, LOAD and UP, and 0 in DOWN.
REQ-029 R SHALL equal latched lo at all times; L=1 only in LOAD.
REQ-030 stop SHALL take priority over all transitions: next state IDLE, E=0 in that cycle, no done pulse.
REQ-031 start while busy SHALL be ignored; latched parameters SHALL not change mid-sweep.
REQ-032 The round counter SHALL be 8 bits; with cycles_l=0 it SHALL wrap freely without effect.
REQ-033 Each extreme dwells one extra step period, because the reversal tick issues no step.

Reset
REQ-034 rst SHALL force IDLE; prescaler, round counter and latched registers to 0; all outputs to 0 except up_down=1.
REQ-035 rst asserted mid-sweep SHALL suppress E and L immediately; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 lo=2, hi=5, div=0, cycles=1, start at cycle 0 -> L=1/R=2 at cycle 1; Q=2,3,4,5 at cycles 2-5; turn at cycle 5; Q=4,3,2 at cycles 7-9; turn and done at cycle 9; busy=0 at cycle 10.
REQ-037 lo=2, hi=5, div=3 -> E pulses exactly every 4th cycle in UP/DOWN; each tick steps Q by one.
REQ-038 lo=5, hi=5 start -> no LOAD, busy stays 0, err pulses once.
REQ-039 cycles=0 -> continuous sweep 2..5..2, no done; stop mid-UP -> E=0 that cycle, IDLE next.
REQ-040 rst during DOWN -> all outputs 0, up_down=1 asynchronously; a new start sweeps normally from lo.
REQ-041 start held high throughout a sweep -> parameters stay latched; a new sweep begins only after IDLE is re-entered.
